// File: rtl/relogio_alarme_if.sv
// Button inputs and display/alarm outputs of relogio_alarme, grouped as one bundle.
interface relogio_alarme_if;
    logic       setState;
    logic       change;
    logic       al_en;
    logic [3:0] min_u;
    logic [3:0] min_d;
    logic [3:0] hora_u;
    logic [3:0] hora_d;
    logic [5:0] seg;
    logic [2:0] modo;
    logic       alarme;
    logic       tick;
    logic [3:0] blank;

    modport master (
        output setState, change, al_en,
        input  min_u, min_d, hora_u, hora_d, seg, modo, alarme, tick, blank
    );

    modport slave (
        input  setState, change, al_en,
        output min_u, min_d, hora_u, hora_d, seg, modo, alarme, tick, blank
    );
endinterface

// File: rtl/relogio_alarme.sv
// HH:MM:SS clock with 1 Hz prescaler, settable alarm and timed alarm output.
// Optional macro BLINK_EN blanks the digit pair being edited during the second half of each second.
module relogio_alarme #(
    parameter int TICK_DIV   = 50000000,
    parameter int HORAS      = 24,
    parameter int ALARME_SEG = 30
) (
    input  logic clk,
    input  logic rst,
    relogio_alarme_if.slave bus
);
    localparam int              PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]   PRESC_ONE = PW'(1);
    localparam logic [3:0]      HMAX_D    = 4'((HORAS - 1) / 10);
    localparam logic [3:0]      HMAX_U    = 4'((HORAS - 1) % 10);
    localparam logic [5:0]      AL_LAST   = 6'(ALARME_SEG - 1);

    typedef enum logic [2:0] {
        RUN         = 3'd0,
        SET_MIN     = 3'd1,
        SET_HORA    = 3'd2,
        SET_AL_MIN  = 3'd3,
        SET_AL_HORA = 3'd4
    } modo_e;

    // BCD pairs are stored as {tens, units}.
    function automatic logic [7:0] inc_min(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5) r = 8'h00;
            else                r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] inc_hora(input logic [7:0] v);
        logic [7:0] r;
        if (v[7:4] == HMAX_D && v[3:0] == HMAX_U) r = 8'h00;
        else if (v[3:0] == 4'd9)                  r = {v[7:4] + 4'd1, 4'd0};
        else                                      r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    modo_e          modo_q, modo_d, modo_nxt_s;
    logic           set_prev_q, chg_prev_q;
    logic           set_edge_s, chg_edge_s;
    logic [PW-1:0]  presc_q, presc_d;
    logic           tick_q, tick_d;
    logic [5:0]     seg_q, seg_d;
    logic [7:0]     mins_q, mins_d, hrs_q, hrs_d;
    logic [7:0]     al_mins_q, al_mins_d, al_hrs_q, al_hrs_d;
    logic           alarme_q, alarme_d, al_hit_s;
    logic [5:0]     al_cnt_q, al_cnt_d;
    logic [15:0]    disp_q, disp_d;
    logic [3:0]     blank_q, blank_d;

    // Button edges; a mode advance masks a simultaneous change press.
    always_comb begin
        set_edge_s = bus.setState & ~set_prev_q;
        chg_edge_s = bus.change & ~chg_prev_q & ~set_edge_s;
    end

    // Mode sequencing.
    always_comb begin
        case (modo_q)
            RUN:         modo_nxt_s = SET_MIN;
            SET_MIN:     modo_nxt_s = SET_HORA;
            SET_HORA:    modo_nxt_s = SET_AL_MIN;
            SET_AL_MIN:  modo_nxt_s = SET_AL_HORA;
            SET_AL_HORA: modo_nxt_s = RUN;
            default:     modo_nxt_s = RUN;
        endcase
        if (set_edge_s)                modo_d = modo_nxt_s;
        else if (modo_q > SET_AL_HORA) modo_d = RUN;
        else                           modo_d = modo_q;
    end

    // Prescaler, timekeeping, editing and alarm timer next state.
    always_comb begin
        presc_d   = (presc_q == PRESC_MAX) ? '0 : presc_q + PRESC_ONE;
        tick_d    = (presc_q == PRESC_MAX);
        seg_d     = seg_q;
        mins_d    = mins_q;
        hrs_d     = hrs_q;
        al_mins_d = al_mins_q;
        al_hrs_d  = al_hrs_q;
        alarme_d  = alarme_q;
        al_cnt_d  = al_cnt_q;

        case (modo_q)
            RUN: begin
                if (tick_q) begin
                    if (seg_q == 6'd59) begin
                        seg_d  = 6'd0;
                        mins_d = inc_min(mins_q);
                        if (mins_q == 8'h59) hrs_d = inc_hora(hrs_q);
                        else                 hrs_d = hrs_q;
                    end else begin
                        seg_d = seg_q + 6'd1;
                    end
                end else begin
                    seg_d = seg_q;
                end
            end
            SET_MIN:     if (chg_edge_s) mins_d    = inc_min(mins_q);     else mins_d    = mins_q;
            SET_HORA:    if (chg_edge_s) hrs_d     = inc_hora(hrs_q);     else hrs_d     = hrs_q;
            SET_AL_MIN:  if (chg_edge_s) al_mins_d = inc_min(al_mins_q);  else al_mins_d = al_mins_q;
            SET_AL_HORA: if (chg_edge_s) al_hrs_d  = inc_hora(al_hrs_q);  else al_hrs_d  = al_hrs_q;
            default:     seg_d = seg_q;
        endcase

        // Entering SET_MIN restarts the second so the edited time starts cleanly.
        if (set_edge_s && modo_q == RUN) begin
            seg_d   = 6'd0;
            presc_d = '0;
        end else begin
            seg_d = seg_d;
        end

        al_hit_s = (modo_q == RUN) && tick_q && (seg_q == 6'd59) && bus.al_en &&
                   ({hrs_d, mins_d} == {al_hrs_q, al_mins_q});

        if (modo_d != RUN || !bus.al_en || (chg_edge_s && modo_q == RUN)) begin
            alarme_d = 1'b0;
            al_cnt_d = 6'd0;
        end else if (al_hit_s) begin
            alarme_d = 1'b1;
            al_cnt_d = 6'd0;
        end else if (alarme_q && tick_q) begin
            if (al_cnt_q == AL_LAST) begin
                alarme_d = 1'b0;
                al_cnt_d = 6'd0;
            end else begin
                al_cnt_d = al_cnt_q + 6'd1;
            end
        end else begin
            alarme_d = alarme_q;
        end
    end

    // Display source and blink mask, computed from next state so outputs track state with no extra lag.
    always_comb begin
        if (modo_d == SET_AL_MIN || modo_d == SET_AL_HORA) disp_d = {al_hrs_d, al_mins_d};
        else                                                disp_d = {hrs_d, mins_d};
`ifdef BLINK_EN
        if (presc_d >= PW'(TICK_DIV / 2)) begin
            case (modo_d)
                SET_MIN, SET_AL_MIN:   blank_d = 4'b0011;
                SET_HORA, SET_AL_HORA: blank_d = 4'b1100;
                default:               blank_d = 4'b0000;
            endcase
        end else begin
            blank_d = 4'b0000;
        end
`else
        blank_d = 4'b0000;
`endif
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            modo_q     <= RUN;
            set_prev_q <= 1'b0;
            chg_prev_q <= 1'b0;
            presc_q    <= '0;
            tick_q     <= 1'b0;
            seg_q      <= 6'd0;
            mins_q     <= 8'h00;
            hrs_q      <= 8'h00;
            al_mins_q  <= 8'h00;
            al_hrs_q   <= 8'h00;
            alarme_q   <= 1'b0;
            al_cnt_q   <= 6'd0;
            disp_q     <= 16'h0000;
            blank_q    <= 4'b0000;
        end else begin
            modo_q     <= modo_d;
            set_prev_q <= bus.setState;
            chg_prev_q <= bus.change;
            presc_q    <= presc_d;
            tick_q     <= tick_d;
            seg_q      <= seg_d;
            mins_q     <= mins_d;
            hrs_q      <= hrs_d;
            al_mins_q  <= al_mins_d;
            al_hrs_q   <= al_hrs_d;
            alarme_q   <= alarme_d;
            al_cnt_q   <= al_cnt_d;
            disp_q     <= disp_d;
            blank_q    <= blank_d;
        end
    end

    assign bus.min_u  = disp_q[3:0];
    assign bus.min_d  = disp_q[7:4];
    assign bus.hora_u = disp_q[11:8];
    assign bus.hora_d = disp_q[15:12];
    assign bus.seg    = seg_q;
    assign bus.modo   = modo_q;
    assign bus.alarme = alarme_q;
    assign bus.tick   = tick_q;
    assign bus.blank  = blank_q;
endmodule

// File: tb/tb_relogio_alarme.sv
// Directed bench for relogio_alarme: a 24 h instance (A) and a 12 h instance (B), TICK_DIV=4.
module tb_relogio_alarme;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    relogio_alarme_if ia();
    relogio_alarme_if ib();

    relogio_alarme #(.TICK_DIV(4), .HORAS(24), .ALARME_SEG(30)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    relogio_alarme #(.TICK_DIV(4), .HORAS(12), .ALARME_SEG(30)) dut_b (.clk(clk), .rst(rst), .bus(ib));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic        c;
        int          rep;
        logic [2:0]  modo;
        logic [15:0] hhmm;
        logic        chk_seg;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic s, input logic c);
        if (sel == 0) begin
            ia.setState = s;
            ia.change   = c;
        end else begin
            ib.setState = s;
            ib.change   = c;
        end
    endtask

    task automatic press(input int sel, input logic s, input logic c);
        drive(sel, s, c);
        step();
        drive(sel, 1'b0, 1'b0);
        step();
    endtask

    task automatic press_n(input int sel, input logic s, input logic c, input int n);
        for (int i = 0; i < n; i++) press(sel, s, c);
    endtask

    function automatic logic [15:0] disp_a();
        return {ia.hora_d, ia.hora_u, ia.min_d, ia.min_u};
    endfunction

    function automatic logic [15:0] disp_b();
        return {ib.hora_d, ib.hora_u, ib.min_d, ib.min_u};
    endfunction

    function automatic logic [30:0] all_a();
        return {ia.min_u, ia.min_d, ia.hora_u, ia.hora_d, ia.seg, ia.modo, ia.alarme, ia.tick, ia.blank};
    endfunction

    function automatic logic [30:0] all_b();
        return {ib.min_u, ib.min_d, ib.hora_u, ib.hora_d, ib.seg, ib.modo, ib.alarme, ib.tick, ib.blank};
    endfunction

    task automatic wait_seg(input int sel, input logic [5:0] v, input string name);
        int n = 0;
        while (((sel == 0) ? ia.seg : ib.seg) != v && n < 400) begin
            step();
            n++;
        end
        check(name, 32'(n < 400), 32'd1);
    endtask

    task automatic wait_seg_change(input int sel, input string name);
        int n = 0;
        logic [5:0] s0;
        s0 = (sel == 0) ? ia.seg : ib.seg;
        while (((sel == 0) ? ia.seg : ib.seg) == s0 && n < 10) begin
            step();
            n++;
        end
        check(name, 32'(n < 10), 32'd1);
    endtask

    task automatic wait_alarm_rise(input logic [15:0] hhmm, input string name);
        int   n = 0;
        logic pt;
        pt = ia.tick;
        while (!ia.alarme && n < 1200) begin
            pt = ia.tick;
            step();
            n++;
        end
        check({name, "_timeout"}, 32'(n < 1200), 32'd1);
        check({name, "_after_tick"}, 32'(pt), 32'd1);
        check({name, "_time"}, {10'd0, disp_a(), ia.seg}, {10'd0, hhmm, 6'd0});
    endtask

    initial begin
        int   cnt;
        int   n;
        int   exp_s;
        int   bad;
        ia.setState = 1'b0; ia.change = 1'b0; ia.al_en = 1'b0;
        ib.setState = 1'b0; ib.change = 1'b0; ib.al_en = 1'b0;

        // rows: press, repeat, expected mode and HH:MM, seg must be 0
        tbl[0]  = '{1'b1, 1'b0, 1,  3'd1, 16'h0001, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 57, 3'd1, 16'h0058, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 2,  3'd1, 16'h0000, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 1,  3'd1, 16'h0001, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 1,  3'd2, 16'h0001, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 9,  3'd2, 16'h0901, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 1,  3'd2, 16'h1001, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 13, 3'd2, 16'h2301, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1,  3'd2, 16'h0001, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 2,  3'd2, 16'h0201, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 1,  3'd3, 16'h0000, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 2,  3'd3, 16'h0002, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 1,  3'd4, 16'h0002, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 1,  3'd4, 16'h0102, 1'b1};
        tbl[14] = '{1'b0, 1'b1, 23, 3'd4, 16'h0002, 1'b1};
        tbl[15] = '{1'b1, 1'b0, 1,  3'd0, 16'h0201, 1'b0};

        rst = 1'b1;
        #12;
        check("reset_a", {1'b0, all_a()}, 32'd0);
        check("reset_b", {1'b0, all_b()}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // free run from reset: tick every 4th edge, seg steps one edge later
        for (int k = 1; k <= 241; k++) begin
            step();
            exp_s = ((k - 1) / 4) % 60;
            check("run_tick", 32'(ia.tick), 32'((k % 4) == 0));
            check("run_seg", {26'd0, ia.seg}, 32'(exp_s));
            check("run_min_u", {28'd0, ia.min_u}, 32'(((k - 1) / 4) / 60));
        end

        for (int r = 0; r < 16; r++) begin
            press_n(0, tbl[r].s, tbl[r].c, tbl[r].rep);
            check($sformatf("tbl_row%0d", r), {13'd0, ia.modo, disp_a()}, {13'd0, tbl[r].modo, tbl[r].hhmm});
            if (tbl[r].chk_seg) check($sformatf("tbl_seg%0d", r), {26'd0, ia.seg}, 32'd0);
        end

        // preload 23:59 and roll over midnight
        press(0, 1'b1, 1'b0);
        press_n(0, 1'b0, 1'b1, 58);
        press(0, 1'b1, 1'b0);
        press_n(0, 1'b0, 1'b1, 21);
        check("preload_2359", {13'd0, ia.modo, disp_a()}, {13'd0, 3'd2, 16'h2359});
        press_n(0, 1'b1, 1'b0, 3);
        wait_seg(0, 6'd59, "wait_2359_59");
        wait_seg_change(0, "wait_midnight");
        check("midnight_a", {10'd0, disp_a(), ia.seg}, 32'd0);

        // alarm 00:02: rises with the 00:02:00 update, lasts 30 ticks
        ia.al_en = 1'b1;
        wait_alarm_rise(16'h0002, "al1_rise");
        cnt = 0;
        n   = 0;
        while (ia.alarme && n < 300) begin
            if (ia.tick) cnt++;
            step();
            n++;
        end
        check("al1_fall_timeout", 32'(n < 300), 32'd1);
        check("al1_tick_count", 32'(cnt), 32'd30);
        check("al1_fall_time", {10'd0, disp_a(), ia.seg}, {10'd0, 16'h0002, 6'd30});

        // alarm 00:03 dismissed by change after 5 ticks
        press_n(0, 1'b1, 1'b0, 3);
        press(0, 1'b0, 1'b1);
        check("al2_set", {13'd0, ia.modo, disp_a()}, {13'd0, 3'd3, 16'h0003});
        press_n(0, 1'b1, 1'b0, 2);
        wait_alarm_rise(16'h0003, "al2_rise");
        cnt = 0;
        n   = 0;
        while (cnt < 5 && n < 100) begin
            if (ia.tick) cnt++;
            step();
            n++;
        end
        check("al2_still_high", 32'(ia.alarme), 32'd1);
        ia.change = 1'b1;
        step();
        check("al2_dismiss", 32'(ia.alarme), 32'd0);
        ia.change = 1'b0;
        step();

        // asynchronous reset mid-count with setState held across release
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_a", {1'b0, all_a()}, 32'd0);
        check("async_rst_b", {1'b0, all_b()}, 32'd0);
        ia.setState = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("held_press_edge", {29'd0, ia.modo}, 32'd1);
        ia.setState = 1'b0;
        step();

        // 12 h instance: 11:59:59 -> 00:00:00
        press(1, 1'b1, 1'b0);
        press_n(1, 1'b0, 1'b1, 59);
        press(1, 1'b1, 1'b0);
        press_n(1, 1'b0, 1'b1, 11);
        check("h12_preload", {13'd0, ib.modo, disp_b()}, {13'd0, 3'd2, 16'h1159});
        cnt = 0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (ib.blank == 4'b1100) cnt++;
            else if (ib.blank != 4'b0000) bad++;
        end
`ifdef BLINK_EN
        check("blank_hora", 32'(cnt * 16 + bad), 32'(2 * 16));
`else
        check("blank_off", 32'(cnt * 16 + bad), 32'd0);
`endif
        press_n(1, 1'b1, 1'b0, 3);
        wait_seg(1, 6'd59, "wait_1159_59");
        wait_seg_change(1, "wait_h12_wrap");
        check("h12_wrap", {10'd0, disp_b(), ib.seg}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
